// File: rtl/audio_sample_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : audio_sample_tx
// Purpose  : Buffers 16-bit mono samples and serializes them to the codec DAC
//            as left-justified stereo frames, with an Avalon-MM control slave.
// Revision : 1.0 - initial release
// ============================================================================
module audio_sample_tx #(
    parameter int BCLK_DIV   = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        aud_bclk,
    output logic        aud_daclrck,
    output logic        aud_dacdat
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_DW = $clog2(2 * BCLK_DIV);
    localparam logic [c_DW-1:0] c_RISE = c_DW'(BCLK_DIV - 1);
    localparam logic [c_DW-1:0] c_FALL = c_DW'(2 * BCLK_DIV - 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);

    logic [15:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_full;

    logic            r_enable;
    logic            r_irq_en;
    logic            r_flag;
    logic [15:0]     r_ucount;
    logic [15:0]     r_word;
    logic            r_started;
    logic [c_DW-1:0] r_div;
    logic [4:0]      r_slot;
    logic            r_bclk;
    logic            r_lrck;
    logic            r_dat;
    logic            r_irq;

    logic            w_wr_ctrl;
    logic            w_wr_ucnt;
    logic            w_en_next;
    logic            w_fall;
    logic            w_frame_start;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_underrun;
    logic [15:0]     w_next_word;
    logic [4:0]      w_next_slot;
    logic [c_CW-1:0] w_count_next;
    logic            w_unused;

    assign w_wr_ctrl    = chipselect & write & (address == 2'd0);
    assign w_wr_ucnt    = chipselect & write & (address == 2'd2);
    // Disabling must silence the outputs on the very edge that takes the write.
    assign w_en_next    = w_wr_ctrl ? writedata[0] : r_enable;
    assign w_fall       = r_started & (r_div == c_FALL);
    assign w_frame_start = w_en_next & r_enable &
                           (~r_started | (w_fall & (r_slot == 5'd31)));
    assign w_empty      = (r_count == '0);
    assign w_push       = sample_valid & ~r_full;
    assign w_pop        = w_frame_start & ~w_empty;
    assign w_underrun   = w_frame_start & w_empty;
    assign w_next_word  = w_empty ? 16'h0000 : r_mem[r_rd_ptr];
    assign w_next_slot  = r_slot + 5'd1;
    assign w_count_next = r_count + c_CW'(w_push) - c_CW'(w_pop);
    assign w_unused     = &{1'b0, writedata[31:3]};

    assign sample_ready = ~r_full;
    assign irq          = r_irq;
    assign aud_bclk     = r_bclk;
    assign aud_daclrck  = r_lrck;
    assign aud_dacdat   = r_dat;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_FULL);
        end
    end

    // Slot sequencer: r_div counts clk cycles inside the current slot.
    always_ff @(posedge clk) begin
        if (reset || !w_en_next) begin
            r_started <= 1'b0;
            r_div     <= '0;
            r_slot    <= 5'd0;
            r_bclk    <= 1'b0;
            r_lrck    <= 1'b0;
            r_dat     <= 1'b0;
        end else if (w_frame_start) begin
            r_started <= 1'b1;
            r_div     <= '0;
            r_slot    <= 5'd0;
            r_bclk    <= 1'b0;
            r_lrck    <= 1'b1;
            r_dat     <= w_next_word[15];
        end else if (r_started) begin
            if (r_div == c_RISE) begin
                r_bclk <= 1'b1;
                r_div  <= r_div + 1'b1;
            end else if (w_fall) begin
                r_bclk <= 1'b0;
                r_div  <= '0;
                r_slot <= w_next_slot;
                r_lrck <= ~w_next_slot[4];
                r_dat  <= r_word[~w_next_slot[3:0]];
            end else begin
                r_div  <= r_div + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_word   <= 16'h0000;
            r_enable <= 1'b0;
            r_irq_en <= 1'b0;
            r_flag   <= 1'b0;
            r_ucount <= 16'h0000;
            r_irq    <= 1'b0;
        end else begin
            if (w_frame_start) begin
                r_word <= w_next_word;
            end
            if (w_wr_ctrl) begin
                r_enable <= writedata[0];
                r_irq_en <= writedata[1];
            end
            // A new underrun wins over a software clear in the same cycle.
            if (w_underrun) begin
                r_flag <= 1'b1;
            end else if (w_wr_ctrl && writedata[2]) begin
                r_flag <= 1'b0;
            end
            if (w_wr_ucnt) begin
                r_ucount <= w_underrun ? 16'h0001 : 16'h0000;
            end else if (w_underrun && (r_ucount != 16'hFFFF)) begin
                r_ucount <= r_ucount + 16'h0001;
            end
            r_irq <= r_irq_en & r_flag;
        end
    end

    always_comb begin
        readdata = 32'h0000_0000;
        case (address)
            2'd0:    readdata = {30'd0, r_irq_en, r_enable};
            2'd1:    readdata = {21'd0, r_flag, r_full, w_empty, 1'b0, 7'(r_count)};
            2'd2:    readdata = {16'd0, r_ucount};
            default: readdata = {16'd0, r_word};
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_audio_sample_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_audio_sample_tx
// Purpose  : Self-checking bench for audio_sample_tx against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_sample_tx;

    localparam int BCLK_DIV     = 2;
    localparam int FIFO_DEPTH   = 8;
    localparam int CLK_PERIOD   = 10;
    localparam int FRAME_CYCLES = 64 * BCLK_DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        aud_bclk;
    logic        aud_daclrck;
    logic        aud_dacdat;

    audio_sample_tx #(.BCLK_DIV(BCLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .readdata(readdata), .irq(irq),
        .aud_bclk(aud_bclk), .aud_daclrck(aud_daclrck), .aud_dacdat(aud_dacdat)
    );

    always #(CLK_PERIOD / 2) clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];
    int exp_underruns = 0;
    logic tb_enable = 1'b0;

    // Codec-side receiver: collects 32 bits per frame on aud_bclk rises.
    int          mon_n = 0;
    int          cap_n = 0;
    logic [31:0] mon_bits = '0;
    logic [31:0] mon_lr = '0;
    time         mon_t0 = 0;
    logic [31:0] cap_data [0:511];
    logic [31:0] cap_lr   [0:511];
    time         cap_t    [0:511];

    always @(posedge aud_bclk or negedge tb_enable) begin
        if (!tb_enable) begin
            mon_n <= 0;
        end else begin
            if (mon_n == 0) mon_t0 <= $time;
            mon_bits <= {mon_bits[30:0], aud_dacdat};
            mon_lr   <= {mon_lr[30:0], aud_daclrck};
            if (mon_n == 31) begin
                if (cap_n < 512) begin
                    cap_data[cap_n] <= {mon_bits[30:0], aud_dacdat};
                    cap_lr[cap_n]   <= {mon_lr[30:0], aud_daclrck};
                    cap_t[cap_n]    <= mon_t0;
                end
                cap_n <= cap_n + 1;
                mon_n <= 0;
            end else begin
                mon_n <= mon_n + 1;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        tb_enable = 1'b0;
        exp_q.delete();
        exp_underruns = 0;
    endtask

    task automatic avm_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        cycle();
        chipselect = 1'b0; write = 1'b0; writedata = '0;
    endtask

    task automatic avm_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic push(input logic [15:0] s);
        sample_in = s; sample_valid = 1'b1;
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(s);
        cycle();
        sample_valid = 1'b0;
    endtask

    // Next word the codec should receive: queue head, or silence on underrun.
    function automatic logic [15:0] model_pop();
        if (exp_q.size() == 0) begin
            exp_underruns++;
            return 16'h0000;
        end
        return exp_q.pop_front();
    endfunction

    task automatic wait_frames(input int target);
        int n = 0;
        while (cap_n < target && n < 40 * FRAME_CYCLES) begin
            cycle();
            n++;
        end
        if (cap_n < target) begin
            errors++;
            $display("FAIL wait_frames: captured %0d frames, required %0d", cap_n, target);
        end
        checks++;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        if (sample_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", sample_ready); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        checks++;
        if ({aud_bclk, aud_daclrck, aud_dacdat} !== 3'b000) begin
            errors++; $display("FAIL reset_codec: got %b want 000", {aud_bclk, aud_daclrck, aud_dacdat});
        end
        checks++;
        avm_read(2'd0, d);
        if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", d); end
        checks++;
        avm_read(2'd1, d);
        if (d !== 32'h100) begin errors++; $display("FAIL reset_status: got %h want 100", d); end
        checks++;
        cycle();
        avm_read(2'd2, d);
        if (d !== 32'h0) begin errors++; $display("FAIL reset_count: got %h want 0", d); end
        checks++;
        avm_read(2'd3, d);
        if (d !== 32'h0) begin errors++; $display("FAIL reset_word: got %h want 0", d); end
        checks++;
    endtask

    task automatic test_underrun_irq();
        logic [31:0] d;
        logic [15:0] w;
        do_reset();
        avm_write(2'd0, 32'h3);
        tb_enable = 1'b1;
        cycle();
        w = model_pop();
        avm_read(2'd1, d);
        if (d[10] !== 1'b1) begin errors++; $display("FAIL underrun_flag: got %b want 1", d[10]); end
        checks++;
        avm_read(2'd2, d);
        if (d !== 32'(exp_underruns)) begin errors++; $display("FAIL underrun_count: got %0d want %0d", d, exp_underruns); end
        checks++;
        avm_read(2'd3, d);
        if (d !== {16'h0, w}) begin errors++; $display("FAIL underrun_word: got %h want %h", d, w); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b want 0", irq); end
        checks++;
        cycle();
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b want 1", irq); end
        checks++;
        avm_write(2'd0, 32'h7);
        avm_read(2'd1, d);
        if (d[10] !== 1'b0) begin errors++; $display("FAIL flag_clear: got %b want 0", d[10]); end
        checks++;
        avm_read(2'd0, d);
        if (d !== 32'h3) begin errors++; $display("FAIL ctrl_readback: got %h want 3", d); end
        checks++;
        cycle();
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b want 0", irq); end
        checks++;
        avm_write(2'd2, 32'h0);
        avm_read(2'd2, d);
        if (d !== 32'h0) begin errors++; $display("FAIL count_clear: got %h want 0", d); end
        checks++;
        avm_write(2'd0, 32'h0);
        tb_enable = 1'b0;
        if ({aud_bclk, aud_daclrck, aud_dacdat} !== 3'b000) begin
            errors++; $display("FAIL disable_codec: got %b want 000", {aud_bclk, aud_daclrck, aud_dacdat});
        end
        checks++;
    endtask

    task automatic test_pattern();
        logic [31:0] d;
        int base;
        do_reset();
        push(16'hA5C3);
        base = cap_n;
        tb_enable = 1'b1;
        avm_write(2'd0, 32'h1);
        if (aud_daclrck !== 1'b0) begin errors++; $display("FAIL start_early: lrck got %b want 0", aud_daclrck); end
        checks++;
        cycle();
        if ({aud_bclk, aud_daclrck, aud_dacdat} !== 3'b011) begin
            errors++; $display("FAIL start_frame: got %b want 011", {aud_bclk, aud_daclrck, aud_dacdat});
        end
        checks++;
        avm_read(2'd3, d);
        if (d !== 32'h0000A5C3) begin errors++; $display("FAIL pattern_word: got %h want 0000a5c3", d); end
        checks++;
        wait_frames(base + 1);
        if (cap_data[base] !== 32'hA5C3A5C3) begin
            errors++; $display("FAIL pattern_bits: got %h want a5c3a5c3", cap_data[base]);
        end
        checks++;
        if (cap_lr[base] !== 32'hFFFF0000) begin
            errors++; $display("FAIL pattern_lrck: got %h want ffff0000", cap_lr[base]);
        end
        checks++;
        avm_write(2'd0, 32'h0);
        tb_enable = 1'b0;
    endtask

    task automatic test_full();
        logic [31:0] d;
        logic [15:0] w;
        int base;
        do_reset();
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            push(16'($urandom));
            if (sample_ready !== (exp_q.size() < FIFO_DEPTH)) begin
                errors++; $display("FAIL full_ready[%0d]: got %b want %b", i, sample_ready, exp_q.size() < FIFO_DEPTH);
            end
            checks++;
        end
        avm_read(2'd1, d);
        if (d !== 32'h208) begin errors++; $display("FAIL full_status: got %h want 208", d); end
        checks++;
        base = cap_n;
        tb_enable = 1'b1;
        avm_write(2'd0, 32'h1);
        wait_frames(base + FIFO_DEPTH);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w = model_pop();
            if (cap_data[base + i] !== {w, w}) begin
                errors++; $display("FAIL full_order[%0d]: got %h want %h", i, cap_data[base + i], {w, w});
            end
            checks++;
        end
        avm_write(2'd0, 32'h0);
        tb_enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [15:0] w;
        int base;
        do_reset();
        for (int i = 0; i < 4; i++) push(16'($urandom));
        base = cap_n;
        tb_enable = 1'b1;
        avm_write(2'd0, 32'h1);
        for (int f = 0; f < 100; f++) begin
            wait_frames(base + f + 1);
            push(16'($urandom));
            w = model_pop();
            if (cap_data[base + f] !== {w, w}) begin
                errors++; $display("FAIL stream_data[%0d]: got %h want %h", f, cap_data[base + f], {w, w});
            end
            checks++;
            if (cap_lr[base + f] !== 32'hFFFF0000) begin
                errors++; $display("FAIL stream_lrck[%0d]: got %h want ffff0000", f, cap_lr[base + f]);
            end
            checks++;
            if (f > 0) begin
                if (cap_t[base + f] - cap_t[base + f - 1] !== time'(FRAME_CYCLES * CLK_PERIOD)) begin
                    errors++; $display("FAIL stream_period[%0d]: got %0t want %0d", f,
                                       cap_t[base + f] - cap_t[base + f - 1], FRAME_CYCLES * CLK_PERIOD);
                end
                checks++;
            end
        end
        avm_read(2'd2, d);
        if (d !== 32'(exp_underruns)) begin errors++; $display("FAIL stream_underruns: got %0d want %0d", d, exp_underruns); end
        checks++;
        avm_write(2'd0, 32'h0);
        tb_enable = 1'b0;
    endtask

    task automatic test_disable_resume();
        logic [31:0] d;
        logic [15:0] w;
        logic [15:0] discarded;
        int base;
        int n;
        do_reset();
        push(16'($urandom));
        push(16'($urandom));
        tb_enable = 1'b1;
        avm_write(2'd0, 32'h1);
        n = 0;
        while (mon_n < 21 && n < 2 * FRAME_CYCLES) begin cycle(); n++; end
        if (mon_n < 21) begin errors++; $display("FAIL resume_reach_k20: got %0d bits want 21", mon_n); end
        checks++;
        avm_write(2'd0, 32'h0);
        tb_enable = 1'b0;
        discarded = exp_q.pop_front();
        if ({aud_bclk, aud_daclrck, aud_dacdat} !== 3'b000) begin
            errors++; $display("FAIL resume_off: got %b want 000", {aud_bclk, aud_daclrck, aud_dacdat});
        end
        checks++;
        push(16'h1234);
        avm_read(2'd1, d);
        if (d !== 32'(exp_q.size())) begin errors++; $display("FAIL resume_fill: got %h want %h (dropped %h)", d, exp_q.size(), discarded); end
        checks++;
        base = cap_n;
        tb_enable = 1'b1;
        avm_write(2'd0, 32'h1);
        wait_frames(base + 1);
        w = model_pop();
        if (cap_data[base] !== {w, w}) begin errors++; $display("FAIL resume_head: got %h want %h", cap_data[base], {w, w}); end
        checks++;
        avm_read(2'd2, d);
        if (d !== 32'(exp_underruns)) begin errors++; $display("FAIL resume_underruns: got %0d want %0d", d, exp_underruns); end
        checks++;
        wait_frames(base + 2);
        w = model_pop();
        if (cap_data[base + 1] !== {w, w}) begin errors++; $display("FAIL resume_next: got %h want %h", cap_data[base + 1], {w, w}); end
        checks++;
        avm_write(2'd0, 32'h0);
        tb_enable = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        logic [15:0] w;
        do_reset();
        for (int i = 0; i < 4; i++) push(16'($urandom));
        tb_enable = 1'b1;
        avm_write(2'd0, 32'h3);
        repeat (40) cycle();
        w = model_pop();
        avm_read(2'd1, d);
        if (d[6:0] !== 7'(exp_q.size())) begin errors++; $display("FAIL midframe_fill: got %0d want %0d", d[6:0], exp_q.size()); end
        checks++;
        avm_read(2'd3, d);
        if (d !== {16'h0, w}) begin errors++; $display("FAIL midframe_word: got %h want %h", d, w); end
        checks++;
        do_reset();
        if ({aud_bclk, aud_daclrck, aud_dacdat, irq} !== 4'b0000) begin
            errors++; $display("FAIL midreset_outputs: got %b want 0000", {aud_bclk, aud_daclrck, aud_dacdat, irq});
        end
        checks++;
        if (sample_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b want 1", sample_ready); end
        checks++;
        avm_read(2'd1, d);
        if (d !== 32'h100) begin errors++; $display("FAIL midreset_status: got %h want 100", d); end
        checks++;
        avm_read(2'd2, d);
        if (d !== 32'h0) begin errors++; $display("FAIL midreset_count: got %h want 0", d); end
        checks++;
        avm_read(2'd0, d);
        if (d !== 32'h0) begin errors++; $display("FAIL midreset_ctrl: got %h want 0", d); end
        checks++;
    endtask

    initial begin
        reset = 1'b1;
        sample_in = '0;
        sample_valid = 1'b0;
        address = '0;
        chipselect = 1'b0;
        write = 1'b0;
        writedata = '0;
        repeat (3) cycle();
        test_reset();
        test_underrun_irq();
        test_pattern();
        test_full();
        test_back_to_back();
        test_disable_resume();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
